// File: rtl/ysyx_24080014_seq_ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encoding,
// fault cause codes, reset PC default and datapath widths.
package ysyx_24080014_seq_ctrl_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned XLEN   = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_RESP   = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } seq_state_e;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_IMEM_ERR = 2'd1,
        FC_MISALIGN = 2'd2,
        FC_TIMEOUT  = 2'd3
    } fault_cause_e;

    // Instructions are word aligned; only the two low address bits matter.
    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_24080014_seq_ctrl_if.sv
// Instruction-memory request/grant/response bus between the sequencer
// (master) and the instruction memory (slave).
interface ysyx_24080014_seq_ctrl_if;
    import ysyx_24080014_seq_ctrl_pkg::*;

    logic              req;
    logic [XLEN-1:0]   addr;
    logic              gnt;
    logic              rvalid;
    logic [INST_W-1:0] rdata;
    logic              err;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata,
        input  err
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata,
        output err
    );
endinterface

// File: rtl/ysyx_24080014_seq_timeout.sv
// Loadable down-counter guarding the EXEC state. clear reloads the counter
// with load_value; while en is high it counts down and sticks at zero.
// expire is high whenever the count is zero.
module ysyx_24080014_seq_timeout #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] load_value,
    output logic             expire
);

    logic [WIDTH-1:0] count_reg;

    // Reload on clear, otherwise count down while enabled until zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= load_value;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign expire = (count_reg == '0);

endmodule

// File: rtl/ysyx_24080014_seq_ctrl.sv
// FETCH -> DECODE -> EXEC -> WB sequencer owning the PC and the
// instruction-memory handshake; stops in HALT on ebreak or a fault.
// Optional macro SEQ_PERF_CNT_EN adds cycle_cnt / instret_cnt outputs.
module ysyx_24080014_seq_ctrl
    import ysyx_24080014_seq_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter int unsigned EXEC_TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    ysyx_24080014_seq_ctrl_if.master    imem,
    output logic [INST_W-1:0]           inst,
    output logic                        inst_valid,
    output logic                        exec_start,
    input  logic                        exec_done,
    input  logic                        br_taken,
    input  logic [31:0]                 br_target,
    input  logic                        wb_need,
    input  logic                        halt_req,
    output logic                        rf_wen,
    output logic [31:0]                 pc,
    output logic                        halted,
    output logic                        fault,
`ifdef SEQ_PERF_CNT_EN
    output logic [63:0]                 cycle_cnt,
    output logic [63:0]                 instret_cnt,
`endif
    output logic [1:0]                  fault_cause
);

    // Counter holds EXEC_TIMEOUT-1 on the first EXEC cycle so that it
    // expires during the EXEC_TIMEOUT-th cycle.
    localparam int unsigned TO_W = (EXEC_TIMEOUT > 1) ? $clog2(EXEC_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(EXEC_TIMEOUT - 1);

    seq_state_e        state_reg, state_next;
    logic [31:0]       pc_reg;
    logic [31:0]       target_reg, target_next;
    logic [31:0]       candidate_pc;
    logic [INST_W-1:0] inst_reg, inst_next;
    fault_cause_e      fault_cause_reg, fault_cause_next;
    logic              rf_wen_next;
    logic              imem_req_reg;
    logic              inst_valid_reg;
    logic              exec_start_reg;
    logic              rf_wen_reg;
    logic              halted_reg;
    logic              resp_fire;
    logic              timeout_expire;

    // A response is consumed either in RESP or, for zero-wait memory,
    // in the same FETCH cycle that is granted.
    assign resp_fire = ((state_reg == S_FETCH) && imem.gnt && imem.rvalid) ||
                       ((state_reg == S_RESP) && imem.rvalid);

    ysyx_24080014_seq_timeout #(
        .WIDTH (TO_W)
    ) u_timeout (
        .clk        (clk),
        .rst        (rst),
        .clear      (state_reg == S_DECODE),
        .en         (state_reg == S_EXEC),
        .load_value (TO_LOAD),
        .expire     (timeout_expire)
    );

    // Next-state, latched instruction, next PC and fault cause.
    always_comb begin
        state_next       = state_reg;
        inst_next        = inst_reg;
        target_next      = target_reg;
        fault_cause_next = fault_cause_reg;
        rf_wen_next      = 1'b0;
        candidate_pc     = br_taken ? br_target : (pc_reg + 32'd4);

        case (state_reg)
            S_IDLE: begin
                state_next = S_FETCH;
            end
            S_FETCH, S_RESP: begin
                if (resp_fire) begin
                    if (imem.err) begin
                        fault_cause_next = FC_IMEM_ERR;
                        state_next       = S_HALT;
                    end else begin
                        inst_next  = imem.rdata;
                        state_next = S_DECODE;
                    end
                end else if ((state_reg == S_FETCH) && imem.gnt) begin
                    state_next = S_RESP;
                end
            end
            S_DECODE: begin
                state_next = halt_req ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (exec_done) begin
                    if (is_misaligned(candidate_pc[1:0])) begin
                        fault_cause_next = FC_MISALIGN;
                        state_next       = S_HALT;
                    end else begin
                        target_next = candidate_pc;
                        rf_wen_next = wb_need;
                        state_next  = S_WB;
                    end
                end else if (timeout_expire) begin
                    fault_cause_next = FC_TIMEOUT;
                    state_next       = S_HALT;
                end
            end
            S_WB: begin
                state_next = S_FETCH;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_HALT;
            end
        endcase
    end

    // State, instruction, redirect target and PC registers; the PC only
    // moves on the WB -> FETCH transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            pc_reg          <= RESET_PC;
            target_reg      <= RESET_PC;
            inst_reg        <= '0;
            fault_cause_reg <= FC_NONE;
        end else begin
            state_reg       <= state_next;
            inst_reg        <= inst_next;
            target_reg      <= target_next;
            fault_cause_reg <= fault_cause_next;
            if (state_reg == S_WB) begin
                pc_reg <= target_reg;
            end
        end
    end

    // Strobes are flops decoded from the next state so they are glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_req_reg   <= 1'b0;
            inst_valid_reg <= 1'b0;
            exec_start_reg <= 1'b0;
            rf_wen_reg     <= 1'b0;
            halted_reg     <= 1'b0;
        end else begin
            imem_req_reg   <= (state_next == S_FETCH);
            inst_valid_reg <= (state_next == S_DECODE);
            exec_start_reg <= (state_next == S_EXEC) && (state_reg != S_EXEC);
            rf_wen_reg     <= rf_wen_next;
            halted_reg     <= (state_next == S_HALT);
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [63:0] cycle_cnt_reg;
    logic [63:0] instret_cnt_reg;

    // Free-running cycle count outside HALT and retired-instruction count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_reg   <= '0;
            instret_cnt_reg <= '0;
        end else begin
            if (state_reg != S_HALT) begin
                cycle_cnt_reg <= cycle_cnt_reg + 64'd1;
            end
            if (state_reg == S_WB) begin
                instret_cnt_reg <= instret_cnt_reg + 64'd1;
            end
        end
    end

    assign cycle_cnt   = cycle_cnt_reg;
    assign instret_cnt = instret_cnt_reg;
`endif

    assign imem.req    = imem_req_reg;
    assign imem.addr   = pc_reg;
    assign inst        = inst_reg;
    assign inst_valid  = inst_valid_reg;
    assign exec_start  = exec_start_reg;
    assign rf_wen      = rf_wen_reg;
    assign pc          = pc_reg;
    assign halted      = halted_reg;
    assign fault       = (fault_cause_reg != FC_NONE);
    assign fault_cause = fault_cause_reg;

endmodule

// File: tb/tb_ysyx_24080014_seq_ctrl.sv
// Self-checking bench for ysyx_24080014_seq_ctrl: a table of per-instruction
// vectors, hand-written reset/halt sequences, and random instructions checked
// against an arithmetic reference model.
module tb_ysyx_24080014_seq_ctrl;

    localparam logic [31:0] RST_PC  = 32'h8000_0000;
    localparam int          EXEC_TO = 16;
    localparam int          NEVER   = 1000;

    typedef struct {
        int          gnt_dly;
        int          rv_dly;
        int          exec_lat;   // NEVER: exec_done is never raised
        logic        err;
        logic        hreq;
        logic        br;
        logic        wb;
        logic [31:0] rdata;
        logic [31:0] target;
        logic [31:0] exp_pc;     // pc after the instruction
        logic [1:0]  exp_cause;
        logic        exp_halt;
        logic        exp_rfwen;
        logic        pre_reset;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst;
    logic        inst_valid, exec_start, exec_done, br_taken;
    logic [31:0] br_target;
    logic        wb_need, halt_req, rf_wen;
    logic [31:0] pc;
    logic        halted, fault;
    logic [1:0]  fault_cause;
`ifdef SEQ_PERF_CNT_EN
    logic [63:0] cycle_cnt, instret_cnt;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model_pc = RST_PC;
    int unsigned cyc = 0;
    int unsigned rfwen_q[$];

    always #5 clk = ~clk;

    ysyx_24080014_seq_ctrl_if bus ();

    ysyx_24080014_seq_ctrl #(
        .RESET_PC     (RST_PC),
        .EXEC_TIMEOUT (EXEC_TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (bus),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .exec_start  (exec_start),
        .exec_done   (exec_done),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .wb_need     (wb_need),
        .halt_req    (halt_req),
        .rf_wen      (rf_wen),
        .pc          (pc),
        .halted      (halted),
        .fault       (fault),
`ifdef SEQ_PERF_CNT_EN
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt),
`endif
        .fault_cause (fault_cause)
    );

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (!rst && rf_wen) rfwen_q.push_back(cyc);

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input int g, input int r, input int lat,
                                input logic err, input logic hreq, input logic br, input logic wb,
                                input logic [31:0] rdata, input logic [31:0] target,
                                input logic [31:0] exp_pc, input logic [1:0] exp_cause,
                                input logic exp_halt, input logic exp_rfwen, input logic pre_reset);
        vec_t v;
        v.gnt_dly = g;      v.rv_dly = r;       v.exec_lat = lat;
        v.err = err;        v.hreq = hreq;      v.br = br;          v.wb = wb;
        v.rdata = rdata;    v.target = target;
        v.exp_pc = exp_pc;  v.exp_cause = exp_cause;
        v.exp_halt = exp_halt; v.exp_rfwen = exp_rfwen; v.pre_reset = pre_reset;
        return v;
    endfunction

    // Reference outcome of one instruction from the architectural rules.
    function automatic vec_t ref_model(input vec_t v, input logic [31:0] cur_pc);
        vec_t        o;
        logic [63:0] seq;
        logic [31:0] nxt;
        o = v;
        seq = 64'(cur_pc) + 64'd4;
        nxt = v.br ? v.target : seq[31:0];
        o.exp_pc = cur_pc; o.exp_halt = 1'b1; o.exp_rfwen = 1'b0; o.exp_cause = 2'd0;
        if (v.err)                    o.exp_cause = 2'd1;
        else if (v.hreq)              o.exp_cause = 2'd0;
        else if (v.exec_lat >= NEVER) o.exp_cause = 2'd3;
        else if ((nxt % 4) != 0)      o.exp_cause = 2'd2;
        else begin
            o.exp_pc = nxt; o.exp_halt = 1'b0; o.exp_rfwen = v.wb;
        end
        return o;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.err = 1'b0;
        exec_done = 1'b0; br_taken = 1'b0; br_target = '0; wb_need = 1'b0; halt_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_pc = RST_PC;
    endtask

    // Walks one instruction through the handshakes and checks the outcome.
    task automatic run_vec(input vec_t v);
        int          waited = 0;
        int          rf0;
        logic [31:0] start_pc;
        while (bus.req !== 1'b1 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check("req_seen", bus.req, 1);
        start_pc = model_pc;
        rf0 = rfwen_q.size();
        bus.rdata = v.rdata;
        bus.err = v.err;
        for (int k = 0; k <= v.gnt_dly; k++) begin
            check("req_held", bus.req, 1);
            check("fetch_addr", bus.addr, model_pc);
            bus.gnt = (k == v.gnt_dly);
            bus.rvalid = (k == v.gnt_dly) && (v.rv_dly == 0);
            @(negedge clk);
        end
        bus.gnt = 1'b0;
        bus.rvalid = 1'b0;
        for (int k = 1; k <= v.rv_dly; k++) begin
            check("req_dropped", bus.req, 0);
            bus.rvalid = (k == v.rv_dly);
            @(negedge clk);
        end
        bus.rvalid = 1'b0;
        bus.err = 1'b0;
        if (!v.err) begin
            check("inst_valid", inst_valid, 1);
            check("inst", inst, v.rdata);
            halt_req = v.hreq;
            @(negedge clk);
            halt_req = 1'b0;
            if (v.hreq) begin
                check("no_exec_start", exec_start, 0);
            end else begin
                check("exec_start", exec_start, 1);
                check("inst_valid_pulse", inst_valid, 0);
                if (v.exec_lat >= NEVER) begin
                    for (int k = 0; k < EXEC_TO; k++) begin
                        check("no_early_halt", halted, 0);
                        @(negedge clk);
                    end
                end else begin
                    for (int k = 0; k <= v.exec_lat; k++) begin
                        if (k > 0) check("exec_start_once", exec_start, 0);
                        check("pc_stable", pc, start_pc);
                        check("inst_stable", inst, v.rdata);
                        exec_done = (k == v.exec_lat);
                        br_taken = v.br;
                        br_target = v.target;
                        wb_need = v.wb;
                        @(negedge clk);
                    end
                    exec_done = 1'b0; br_taken = 1'b0; wb_need = 1'b0;
                    if (!v.exp_halt) begin
                        check("rf_wen", rf_wen, v.exp_rfwen);
                        check("pc_in_wb", pc, start_pc);
                        @(negedge clk);
                    end else begin
                        check("no_rf_wen", rf_wen, 0);
                    end
                end
            end
        end
        #1;
        check("halted", halted, v.exp_halt);
        check("fault_cause", fault_cause, v.exp_cause);
        check("fault", fault, v.exp_cause != 2'd0);
        check("pc", pc, v.exp_pc);
        check("rfwen_count", rfwen_q.size() - rf0, v.exp_rfwen);
        if (v.exp_halt) check("req_off_in_halt", bus.req, 0);
        model_pc = v.exp_pc;
    endtask

    vec_t tbl[12];

    initial begin
        bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.err = 1'b0;
        exec_done = 1'b0; br_taken = 1'b0; br_target = '0; wb_need = 1'b0; halt_req = 1'b0;
        do_reset();
        #1;
        check("rst_req", bus.req, 0);
        check("rst_pc", pc, RST_PC);
        check("rst_inst", inst, 0);
        check("rst_halted", halted, 0);
        check("rst_fault", fault, 0);
        check("rst_cause", fault_cause, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_exec_start", exec_start, 0);
        check("rst_rf_wen", rf_wen, 0);
        rfwen_q.delete();

        //          gnt rv lat err hrq br wb  rdata          target         exp_pc        cause hlt rfw rst
        tbl[0]  = mk(0, 0, 0,  0, 0, 0, 1, 32'h0010_0093, 32'h0,         32'h8000_0004, 0, 0, 1, 0);
        tbl[1]  = mk(0, 0, 0,  0, 0, 0, 1, 32'h0020_0113, 32'h0,         32'h8000_0008, 0, 0, 1, 0);
        tbl[2]  = mk(0, 0, 0,  0, 0, 0, 1, 32'h0030_0193, 32'h0,         32'h8000_000C, 0, 0, 1, 0);
        tbl[3]  = mk(3, 2, 2,  0, 0, 0, 0, 32'h0050_0093, 32'h0,         32'h8000_0010, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 1,  0, 0, 1, 1, 32'h0000_0063, 32'h8000_0100, 32'h8000_0100, 0, 0, 1, 0);
        tbl[5]  = mk(1, 0, 0,  0, 0, 1, 1, 32'h0000_006F, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0, 1, 0);
        tbl[6]  = mk(0, 1, 0,  0, 0, 0, 1, 32'h0010_0093, 32'h0,         32'h0000_0000, 0, 0, 1, 0);
        tbl[7]  = mk(0, 0, 3,  0, 0, 1, 1, 32'h0000_0063, 32'h8000_0102, 32'h0000_0000, 2, 1, 0, 0);
        tbl[8]  = mk(1, 1, 0,  1, 0, 0, 1, 32'h0000_0000, 32'h0,         32'h8000_0000, 1, 1, 0, 1);
        tbl[9]  = mk(0, 0, NEVER, 0, 0, 0, 1, 32'h0000_0033, 32'h0,      32'h8000_0000, 3, 1, 0, 1);
        tbl[10] = mk(2, 0, 0,  0, 0, 0, 1, 32'h0070_0093, 32'h0,         32'h8000_0004, 0, 0, 1, 1);
        tbl[11] = mk(0, 0, 0,  0, 1, 0, 0, 32'h0010_0073, 32'h0,         32'h8000_0004, 0, 1, 0, 0);

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].pre_reset) do_reset();
            run_vec(tbl[i]);
        end
        check("rfwen_gap_0_1", (rfwen_q.size() >= 2) ? rfwen_q[1] - rfwen_q[0] : 0, 4);
        check("rfwen_gap_1_2", (rfwen_q.size() >= 3) ? rfwen_q[2] - rfwen_q[1] : 0, 4);

        // HALT after ebreak is absorbing: no request and no strobes.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("halt_no_req", bus.req, 0);
            check("halt_no_strobe", {exec_start, inst_valid, rf_wen}, 0);
            check("halt_sticky", halted, 1);
        end

        // Reset in the middle of RESP; a stale rvalid in IDLE is ignored.
        do_reset();
        run_vec(mk(0, 0, 0, 0, 0, 0, 1, 32'h00A0_0093, 32'h0, RST_PC + 32'd4, 0, 0, 1, 0));
        check("pre_rst_req", bus.req, 1);
        bus.gnt = 1'b1;
        @(negedge clk);
        bus.gnt = 1'b0;
        check("resp_req_low", bus.req, 0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_pc", pc, RST_PC);
        check("async_rst_inst", inst, 0);
        check("async_rst_req", bus.req, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.rvalid = 1'b1;
        bus.rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.rvalid = 1'b0;
        check("post_rst_req", bus.req, 1);
        check("post_rst_addr", bus.addr, RST_PC);
        check("stale_inst", inst, 0);
        check("stale_inst_valid", inst_valid, 0);
        model_pc = RST_PC;
        run_vec(mk(0, 0, 0, 0, 0, 0, 1, 32'h00B0_0093, 32'h0, RST_PC + 32'd4, 0, 0, 1, 0));

        // Random instruction stream against the reference model.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            vec_t        v;
            logic [31:0] tgt;
            tgt = $urandom;
            if ($urandom_range(7) != 0) tgt[1:0] = 2'b00;
            v = mk($urandom_range(3), $urandom_range(2),
                   ($urandom_range(39) == 0) ? NEVER : $urandom_range(5),
                   $urandom_range(29) == 0, $urandom_range(19) == 0,
                   $urandom_range(2) == 0, 1'($urandom_range(1)),
                   $urandom, tgt, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
            v = ref_model(v, model_pc);
            run_vec(v);
            if (v.exp_halt) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_24080014_seq_ctrl.md
Name: ysyx_24080014_seq_ctrl

Overview:
Multi-cycle sequencer that drives the IFU/IDU/ALU datapath as a FETCH→DECODE→EXEC→WB loop instead of a free-running PC.
- Owns the PC and the instruction-memory request/grant/response handshake.
- Latches the fetched instruction, issues start strobes to execute, gates register-file writeback and selects the next PC.
- Stops in HALT on ebreak or on a fault.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset
EXEC_TIMEOUT, 16, max cycles in EXEC waiting for exec_done before fault (≥1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request, held until granted
imem_addr  out  32  fetch address (= pc)
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  instruction data valid
imem_rdata  in  32  instruction word
imem_err  in  1  access error, qualified by imem_rvalid
inst  out  32  latched instruction, stable from DECODE through WB
inst_valid  out  1  one-cycle pulse in DECODE
exec_start  out  1  one-cycle pulse on entry to EXEC
exec_done  in  1  execute result ready
br_taken  in  1  redirect PC to br_target, sampled with exec_done
br_target  in  32  redirect address
wb_need  in  1  instruction writes rd (rd≠0), sampled with exec_done
halt_req  in  1  decoded ebreak, sampled in DECODE
rf_wen  out  1  register-file write enable, one-cycle pulse in WB
pc  out  32  current PC
halted  out  1  sticky, set in HALT
fault  out  1  sticky error flag
fault_cause  out  2  0 none, 1 imem_err, 2 misaligned target, 3 exec timeout

Behaviour:
- Reset (async, any state):
  - State IDLE; pc=RESET_PC; inst=0.
  - All strobes 0; halted=0; fault=0; fault_cause=0.
  - An in-flight fetch is abandoned; a late imem_rvalid after reset is ignored while in IDLE.
- IDLE: one cycle, then FETCH.
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_gnt: go to RESP.
  - If imem_rvalid is also high that cycle, treat it as the response immediately (zero-wait memory).
- RESP: wait for imem_rvalid.
  - imem_err=1: fault_cause=1 → HALT.
  - Otherwise latch inst=imem_rdata → DECODE.
- DECODE: one cycle; inst_valid=1.
  - halt_req=1: pc unchanged → HALT, no EXEC, no WB.
  - Otherwise → EXEC.
- EXEC: exec_start pulses on the first EXEC cycle only; an internal timeout counter is cleared on entry.
  - exec_done=1: compute next = br_taken ? br_target : pc+4.
    - Addition wraps modulo 2^32.
    - next[1:0]≠0: fault_cause=2 → HALT, pc unchanged.
    - Otherwise register next, wb_need → WB.
  - Counter reaches EXEC_TIMEOUT without exec_done: fault_cause=3 → HALT.
  - exec_done in the same cycle as exec_start is legal (single-cycle ALU). Total latency is 4 cycles/instruction with zero-wait memory.
- WB: rf_wen=wb_need for exactly one cycle; pc←next → FETCH.
- HALT: absorbing until rst.
  - halted=1, no further strobes.
  - fault=1 iff fault_cause≠0.
- Output timing:
  - imem_req, rf_wen, inst_valid and exec_start are registered state decodes, glitch-free.
  - pc changes only in WB→FETCH.

Optional Feature:
SEQ_PERF_CNT_EN:
- Defined: adds outputs cycle_cnt[63:0] and instret_cnt[63:0], both reset to 0.
  - cycle_cnt increments every non-HALT cycle.
  - instret_cnt increments on each WB.
  - Both wrap at 2^64.
- Undefined: ports and logic absent; no other behaviour change.

Decomposition:
- Shared package: state enum (IDLE, FETCH, RESP, DECODE, EXEC, WB, HALT), fault_cause encodings, RESET_PC default, instruction width constant.
- One natural sub-module, ysyx_24080014_seq_timeout: a loadable down-counter with a clear input and an expire output, used for EXEC_TIMEOUT.

Test Plan:
- Zero-wait memory (gnt and rvalid in the FETCH cycle), 3 addi with wb_need=1 → pc 8000_0000→…04→…08→…0C; rf_wen pulses every 4th cycle; 3 inst_valid pulses.
- imem_gnt delayed 3 cycles, rvalid 2 cycles after gnt → imem_req held 4 cycles, addr constant; inst latched with value 0x00500093.
- br_taken=1, br_target=8000_0100 → next fetch addr 8000_0100. br_target=8000_0102 → fault=1, fault_cause=2, halted=1, no rf_wen.
- pc=FFFF_FFFC, no branch → wraps to 0000_0000 (drive via br_target).
- halt_req in DECODE → halted=1, fault=0, no exec_start, imem_req stays 0 for 20 cycles.
- exec_done never asserted with EXEC_TIMEOUT=16 → fault_cause=3 after 16 EXEC cycles.
- rst pulsed mid-RESP → pc=8000_0000, state IDLE; stale rvalid ignored.
